// File: rtl/led_pio_pwm.sv
// led_pio_pwm: memory-mapped LED output port with per-channel blink and a global PWM dimmer.
// Blink timing is a prescaled tick driving a half-period counter; PWM is a free-running compare.
module led_pio_pwm #(
    parameter int                WIDTH         = 8,
    parameter int                PWM_BITS      = 8,
    parameter int                PRESCALE_BITS = 16,
    parameter logic [WIDTH-1:0]  RESET_VALUE   = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] A_DATA       = 3'd0;
    localparam logic [2:0] A_MODE       = 3'd1;
    localparam logic [2:0] A_OUTSET     = 3'd2;
    localparam logic [2:0] A_OUTCLEAR   = 3'd3;
    localparam logic [2:0] A_DUTY       = 3'd4;
    localparam logic [2:0] A_PRESCALE   = 3'd5;
    localparam logic [2:0] A_BLINK_HALF = 3'd6;
    localparam logic [2:0] A_STATUS     = 3'd7;

    logic [WIDTH-1:0]         data_q, data_d;
    logic [WIDTH-1:0]         mode_q, mode_d;
    logic [PWM_BITS-1:0]      duty_q, duty_d;
    logic [PRESCALE_BITS-1:0] prescale_q, prescale_d;
    logic [15:0]              blink_half_q, blink_half_d;
    logic [PRESCALE_BITS-1:0] pre_cnt_q, pre_cnt_d;
    logic [15:0]              blink_cnt_q, blink_cnt_d;
    logic                     phase_q, phase_d;
    logic [PWM_BITS-1:0]      pwm_cnt_q, pwm_cnt_d;
    logic [WIDTH-1:0]         out_q, out_d;

    logic             wr, cfg_wr, tick, blink_last, pwm_on;
    logic [WIDTH-1:0] wval;
    logic [15:0]      blink_end;

    assign wr     = chipselect & ~write_n;
    assign wval   = writedata[WIDTH-1:0];
    assign cfg_wr = wr && (address == A_PRESCALE || address == A_BLINK_HALF);

    always_comb begin
        data_d       = (wr && address == A_DATA)       ? wval :
                       (wr && address == A_OUTSET)     ? data_q | wval :
                       (wr && address == A_OUTCLEAR)   ? data_q & ~wval : data_q;
        mode_d       = (wr && address == A_MODE)       ? wval : mode_q;
        duty_d       = (wr && address == A_DUTY)       ? writedata[PWM_BITS-1:0] : duty_q;
        prescale_d   = (wr && address == A_PRESCALE)   ? writedata[PRESCALE_BITS-1:0] : prescale_q;
        blink_half_d = (wr && address == A_BLINK_HALF) ? writedata[15:0] : blink_half_q;
    end

    // A half-period of 0 behaves as 1 so the blink counter always has a valid end point.
    assign tick       = pre_cnt_q == prescale_q;
    assign blink_end  = (blink_half_q == 16'd0) ? 16'd0 : blink_half_q - 16'd1;
    assign blink_last = blink_cnt_q == blink_end;
    assign pwm_on     = (&duty_q) | (pwm_cnt_q < duty_q);

    // Retiming writes restart the blink cycle from a known lit state.
    always_comb begin
        pre_cnt_d   = (cfg_wr || tick) ? '0 : pre_cnt_q + PRESCALE_BITS'(1);
        blink_cnt_d = cfg_wr ? 16'd0 : !tick ? blink_cnt_q : blink_last ? 16'd0 : blink_cnt_q + 16'd1;
        phase_d     = cfg_wr ? 1'b1 : (tick && blink_last) ? ~phase_q : phase_q;
        pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
        out_d       = data_q & (~mode_q | {WIDTH{phase_q}}) & {WIDTH{pwm_on}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q       <= RESET_VALUE;
            mode_q       <= '0;
            duty_q       <= '1;
            prescale_q   <= '0;
            blink_half_q <= '0;
            pre_cnt_q    <= '0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b1;
            pwm_cnt_q    <= '0;
            out_q        <= '0;
        end else begin
            data_q       <= data_d;
            mode_q       <= mode_d;
            duty_q       <= duty_d;
            prescale_q   <= prescale_d;
            blink_half_q <= blink_half_d;
            pre_cnt_q    <= pre_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            pwm_cnt_q    <= pwm_cnt_d;
            out_q        <= out_d;
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            A_DATA:       readdata = 32'(data_q);
            A_MODE:       readdata = 32'(mode_q);
            A_DUTY:       readdata = 32'(duty_q);
            A_PRESCALE:   readdata = 32'(prescale_q);
            A_BLINK_HALF: readdata = 32'(blink_half_q);
            A_STATUS:     readdata = {30'd0, pwm_on, phase_q};
            default:      readdata = 32'd0;
        endcase
    end

    assign out_port = out_q;

endmodule

// File: tb/tb_led_pio_pwm.sv
// tb_led_pio_pwm: random and directed stimulus checked against a time-based model of the LED port.
module tb_led_pio_pwm;

    logic        clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, write_n = 1'b1;
    logic [2:0]  address = 3'd0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    led_pio_pwm #(.WIDTH(8), .PWM_BITS(8), .PRESCALE_BITS(16), .RESET_VALUE(8'hA5)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: blink phase and PWM position follow from elapsed edges since the last retime/reset.
    logic [7:0] m_data = 8'hA5, m_mode = 8'h00, m_duty = 8'hFF, m_out = 8'h00;
    longint     m_pre = 0, m_bh = 0, n_cfg = 0, t_rst = 0;

    function automatic bit m_phase();
        longint per = (m_pre + 1) * ((m_bh == 0) ? 1 : m_bh);
        return ((n_cfg / per) % 2) == 0;
    endfunction

    function automatic bit m_pwm();
        return (m_duty == 8'hFF) || ((t_rst % 256) < longint'(m_duty));
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {24'd0, m_data};
            3'd1:    return {24'd0, m_mode};
            3'd4:    return {24'd0, m_duty};
            3'd5:    return 32'(m_pre);
            3'd6:    return 32'(m_bh);
            3'd7:    return {30'd0, m_pwm(), m_phase()};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_data = 8'hA5; m_mode = 8'h00; m_duty = 8'hFF; m_out = 8'h00;
            m_pre = 0; m_bh = 0; n_cfg = 0; t_rst = 0;
        end else begin
            m_out = m_data & (~m_mode | {8{m_phase()}}) & {8{m_pwm()}};
            t_rst++;
            n_cfg++;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data = writedata[7:0];
                    3'd1: m_mode = writedata[7:0];
                    3'd2: m_data = m_data | writedata[7:0];
                    3'd3: m_data = m_data & ~writedata[7:0];
                    3'd4: m_duty = writedata[7:0];
                    3'd5: begin m_pre = longint'(writedata[15:0]); n_cfg = 0; end
                    3'd6: begin m_bh = longint'(writedata[15:0]); n_cfg = 0; end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && reset_n) begin
            check("out_port", 32'(out_port), 32'(m_out));
            check("readdata", readdata, m_read(address));
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk); #1;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        #23;
        address = 3'd4; #1;
        check("rst_out", 32'(out_port), 32'h0);
        check("rst_duty", readdata, 32'hFF);
        address = 3'd0; #1;
        check("rst_data", readdata, 32'hA5);
        @(negedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        check("first_out", 32'(out_port), 32'hA5);
        chk_en = 1'b1;

        wr(3'd0, 32'h0F); wr(3'd2, 32'hF0); wr(3'd3, 32'h03);
        address = 3'd0; #1;
        check("data_rb", readdata, 32'hFC);
        @(negedge clk);
        check("out_fc", 32'(out_port), 32'hFC);

        wr(3'd1, 32'h01); wr(3'd0, 32'h01); wr(3'd5, 32'd3); wr(3'd6, 32'd2);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            check("blink8", 32'(out_port), (k <= 8 || k > 16) ? 32'h01 : 32'h00);
        end

        wr(3'd1, 32'h00); wr(3'd0, 32'hFF); wr(3'd4, 32'h40);
        cnt = 0;
        repeat (256) begin @(negedge clk); cnt += int'(out_port[0]); end
        check("duty40", 32'(cnt), 32'd64);
        wr(3'd4, 32'h00);
        cnt = 0;
        repeat (256) begin @(negedge clk); cnt += int'(out_port[3]); end
        check("duty00", 32'(cnt), 32'd0);
        wr(3'd4, 32'hFF);
        cnt = 0;
        repeat (256) begin @(negedge clk); cnt += int'(out_port[7]); end
        check("dutyFF", 32'(cnt), 32'd256);

        wr(3'd5, 32'd1); wr(3'd6, 32'd3); wr(3'd1, 32'hFF);
        address = 3'd7;
        repeat (7) @(negedge clk);
        check("pre_rewrite", 32'(readdata[0]), 32'd0);
        wr(3'd6, 32'd3);
        address = 3'd7; #1;
        check("rewrite_phase", 32'(readdata[0]), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 5) check("toggle_wait", 32'(readdata[0]), 32'd1);
            if (k == 6) check("toggle_at6", 32'(readdata[0]), 32'd0);
        end

        @(posedge clk); #2;
        reset_n = 1'b0; #1;
        check("mid_rst_out", 32'(out_port), 32'h0);
        address = 3'd0; #1;
        check("mid_rst_data", readdata, 32'hA5);
        @(posedge clk); @(negedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_out", 32'(out_port), 32'hA5);

        for (int i = 0; i < 2500; i++) begin
            @(negedge clk); #1;
            if (i == 1200) begin
                reset_n = 1'b0; #1;
                check("rnd_rst", 32'(out_port), 32'h0);
            end
            if (i == 1203) reset_n = 1'b1;
            address    = 3'($urandom_range(0, 7));
            chipselect = $urandom_range(0, 2) == 0;
            write_n    = 1'($urandom_range(0, 1));
            writedata  = (address == 3'd5) ? $urandom_range(0, 3) :
                         (address == 3'd6) ? $urandom_range(0, 4) : $urandom;
        end
        chipselect = 1'b0; write_n = 1'b1;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
